// File: rtl/uart_apb_pkg.sv
// rtl/uart_apb_pkg.sv - register map, bit indices and widths shared by the UART RX APB FIFO
package uart_apb_pkg;

    localparam int APB_DW  = 32;
    localparam int LEVEL_W = 9;

    localparam logic [3:0] ADDR_DATA   = 4'h0;
    localparam logic [3:0] ADDR_STATUS = 4'h4;
    localparam logic [3:0] ADDR_CTRL   = 4'h8;
    localparam logic [3:0] ADDR_THRESH = 4'hC;

    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVERRUN   = 2;
    localparam int ST_TIMEOUT   = 3;
    localparam int ST_LEVEL_LSB = 8;

    localparam int CTRL_IRQ_EN = 0;
    localparam int CTRL_FLUSH  = 1;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with flush; a push into a full FIFO succeeds only alongside a pop
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    // Flush wins over any same-cycle push or pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      level <= level + LW'(1);
            else if (do_pop && !do_push) level <= level - LW'(1);
        end
    end

endmodule

// File: rtl/uart_rx_apb_fifo.sv
// rtl/uart_rx_apb_fifo.sv - UART RX FIFO behind an APB register slave with irq; RX_FIFO_TIMEOUT_EN adds idle timeout
module uart_rx_apb_fifo
    import uart_apb_pkg::*;
#(
    parameter int PAYLOAD_BITS   = 8,
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rx_valid,
    input  logic [PAYLOAD_BITS-1:0] rx_data,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [3:0]              paddr,
    input  logic [31:0]             pwdata,
    output logic [31:0]             prdata,
    output logic                    pready,
    output logic                    pslverr,
    output logic                    irq
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic                    acc;
    logic [3:0]              word_addr;
    logic                    wr_ok;
    logic                    st_wr;
    logic                    data_rd;
    logic                    fifo_flush;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic [PAYLOAD_BITS-1:0] fifo_dout;
    logic [LW-1:0]           fifo_level;
    logic [LEVEL_W-1:0]      level_ext;
    logic                    overrun;
    logic                    overrun_set;
    logic                    timeout;
    logic                    irq_en;
    logic [8:0]              thresh;
    logic                    unused_bits;

    assign acc         = psel & penable;
    assign word_addr   = {paddr[3:2], 2'b00};
    assign pready      = 1'b1;
    // paddr is 4 bits wide, so every access decodes to one of the four registers.
    assign pslverr     = acc & pwrite & (word_addr == ADDR_DATA);
    assign wr_ok       = acc & pwrite & ~pslverr;
    assign st_wr       = wr_ok & (word_addr == ADDR_STATUS);
    assign data_rd     = acc & ~pwrite & (word_addr == ADDR_DATA);
    assign fifo_flush  = wr_ok & (word_addr == ADDR_CTRL) & pwdata[CTRL_FLUSH];
    assign overrun_set = rx_valid & fifo_full & ~data_rd;
    assign level_ext   = LEVEL_W'(fifo_level);
    assign unused_bits = ^{pwdata, paddr[1:0]};

    sync_fifo #(
        .WIDTH (PAYLOAD_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_valid),
        .pop   (data_rd),
        .flush (fifo_flush),
        .din   (rx_data),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .level (fifo_level)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_en  <= 1'b0;
            thresh  <= 9'd1;
            overrun <= 1'b0;
            irq     <= 1'b0;
        end else begin
            if (wr_ok && word_addr == ADDR_CTRL) irq_en <= pwdata[CTRL_IRQ_EN];
            if (wr_ok && word_addr == ADDR_THRESH) begin
                thresh <= (pwdata[8:0] == 9'd0) ? 9'd1 : pwdata[8:0];
            end
            if (overrun_set)                    overrun <= 1'b1;
            else if (st_wr && pwdata[ST_OVERRUN]) overrun <= 1'b0;
            irq <= irq_en & ((level_ext >= thresh) | overrun | timeout);
        end
    end

`ifdef RX_FIFO_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] idle_cnt;
    logic          fifo_pop;
    logic          fifo_push;
    logic          fifo_busy;
    logic          idle_hit;

    assign fifo_pop  = data_rd & ~fifo_empty;
    assign fifo_push = rx_valid & (~fifo_full | fifo_pop);
    assign fifo_busy = fifo_push | fifo_pop | fifo_flush | fifo_empty;
    assign idle_hit  = ~fifo_busy & (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            if (fifo_busy)      idle_cnt <= '0;
            else if (!idle_hit) idle_cnt <= idle_cnt + TW'(1);
            if (idle_hit)                         timeout <= 1'b1;
            else if (st_wr && pwdata[ST_TIMEOUT]) timeout <= 1'b0;
        end
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    always_comb begin
        prdata = '0;
        if (acc && !pwrite) begin
            case (word_addr)
                ADDR_DATA:   prdata = APB_DW'(fifo_dout);
                ADDR_STATUS: begin
                    prdata[ST_EMPTY]   = fifo_empty;
                    prdata[ST_FULL]    = fifo_full;
                    prdata[ST_OVERRUN] = overrun;
                    prdata[ST_TIMEOUT] = timeout;
                    prdata[ST_LEVEL_LSB +: LEVEL_W] = level_ext;
                end
                ADDR_CTRL:   prdata[CTRL_IRQ_EN] = irq_en;
                default:     prdata[8:0] = thresh;
            endcase
        end
    end

endmodule
